mod_counter_gen: RTL and testbench

- Parametrised modulo-N counter generalising the team's fixed 3-bit counter.
- Adds configurable width and modulus, up/down counting, synchronous load and clear, a one-cycle terminal-count pulse, and a sticky wrap indicator.
- Used as a timing/sequence generator for FSM pacing and event counting in the embedded datapath.

---
 rtl/mod_counter_pkg.sv | 23 ++
 rtl/mod_prescaler.sv | 28 ++
 rtl/mod_counter_gen.sv | 111 +++++++++++
 tb/tb_mod_counter_gen.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mod_counter_pkg.sv
// Shared constants and helpers for the modulo-N counter: direction encoding,
// saturating load and parameter legality checks.
package mod_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int unsigned MIN_MODULUS      = 2;
  localparam int unsigned MIN_PRESCALE_DIV = 1;

  // A modulus must give at least two states and fit in the counter width.
  function automatic bit modulus_legal(input int unsigned width, input int unsigned modulus);
    longint unsigned span;
    span = longint'(1) << width;
    return (modulus >= MIN_MODULUS) && (longint'(modulus) <= span);
  endfunction

  // Out-of-range load values clamp to the top state instead of wrapping.
  function automatic int unsigned sat_load(input int unsigned value, input int unsigned modulus);
    return (value < modulus) ? value : modulus - 1;
  endfunction

endpackage

// File: rtl/mod_prescaler.sv
// Counts enabled cycles 0..DIV-1 and flags the cycle that completes a period.
// Only instantiated when MOD_COUNTER_PRESCALE_EN is defined.
module mod_prescaler #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clr,
  output logic tick
);

  localparam int unsigned     CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign tick = enable && (r_cnt == LAST);

endmodule

// File: rtl/mod_counter_gen.sv
// Parametrised modulo-N up/down counter with load, clear, terminal-count pulse
// and sticky wrap flag. Define MOD_COUNTER_PRESCALE_EN to divide the step rate.
module mod_counter_gen
  import mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH        = 3,
  parameter int unsigned MODULUS      = 7,
  parameter int unsigned PRESCALE_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear,
  input  logic             sticky_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             active,
  output logic             wrap_sticky
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  if (!modulus_legal(WIDTH, MODULUS)) begin : g_bad_modulus
    $error("mod_counter_gen: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end
  if (PRESCALE_DIV < MIN_PRESCALE_DIV) begin : g_bad_prescale
    $error("mod_counter_gen: PRESCALE_DIV must be >= 1");
  end

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_active;
  logic             r_sticky;

  logic             w_tick;
  logic             w_step;
  logic             w_wrap;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_load_sat;

`ifdef MOD_COUNTER_PRESCALE_EN
  mod_prescaler #(.DIV(PRESCALE_DIV)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clr    (clear | load),
    .tick   (w_tick)
  );
`else
  assign w_tick = enable;
`endif

  // Wrap is decided by comparing before the increment, so MODULUS = 2**WIDTH
  // still produces tc through the explicit compare.
  assign w_step = w_tick && !clear && !load;
  assign w_wrap = w_step && ((up_down == DIR_UP) ? (r_count == MAX_VAL) : (r_count == '0));

  always_comb begin
    w_next = r_count;
    if (up_down == DIR_UP) begin
      w_next = (r_count == MAX_VAL) ? '0 : r_count + 1'b1;
    end else begin
      w_next = (r_count == '0) ? MAX_VAL : r_count - 1'b1;
    end
  end

  assign w_load_sat = WIDTH'(sat_load(32'(load_value), MODULUS));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count  <= '0;
      r_tc     <= 1'b0;
      r_active <= 1'b0;
    end else if (clear) begin
      r_count  <= '0;
      r_tc     <= 1'b0;
      r_active <= 1'b0;
    end else if (load) begin
      r_count  <= w_load_sat;
      r_tc     <= 1'b0;
      r_active <= 1'b0;
    end else if (w_step) begin
      r_count  <= w_next;
      r_tc     <= w_wrap;
      r_active <= 1'b1;
    end else begin
      r_tc     <= 1'b0;
      r_active <= 1'b0;
    end
  end

  // A wrap in the same cycle as sticky_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sticky <= 1'b0;
    end else if (w_wrap) begin
      r_sticky <= 1'b1;
    end else if (sticky_clr) begin
      r_sticky <= 1'b0;
    end
  end

  assign count       = r_count;
  assign tc          = r_tc;
  assign active      = r_active;
  assign wrap_sticky = r_sticky;

endmodule

// File: tb/tb_mod_counter_gen.sv
// Self-checking bench for mod_counter_gen: table-driven vectors with a
// scoreboard queue, plus MODULUS=2**WIDTH and prescaler sequences.
module tb_mod_counter_gen;

  typedef struct packed {
    logic       rst_n;
    logic       en;
    logic       ud;
    logic       ld;
    logic [2:0] lv;
    logic       clr;
    logic       sclr;
    logic [2:0] cnt;
    logic       tc;
    logic       act;
    logic       stk;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       up_down;
  logic       load;
  logic [2:0] load_value;
  logic       clear;
  logic       sticky_clr;

  logic [2:0] count7, count8;
  logic       tc7, tc8, act7, act8, stk7, stk8;

  logic [5:0] exp_q[$];
  logic [5:0] exp8_q[$];
  vec_t       vecs[$];

  int n_checks = 0;
  int n_fail   = 0;

  mod_counter_gen #(.WIDTH(3), .MODULUS(7), .PRESCALE_DIV(4)) u_dut7 (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .up_down     (up_down),
    .load        (load),
    .load_value  (load_value),
    .clear       (clear),
    .sticky_clr  (sticky_clr),
    .count       (count7),
    .tc          (tc7),
    .active      (act7),
    .wrap_sticky (stk7)
  );

  mod_counter_gen #(.WIDTH(3), .MODULUS(8), .PRESCALE_DIV(4)) u_dut8 (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .up_down     (up_down),
    .load        (load),
    .load_value  (load_value),
    .clear       (clear),
    .sticky_clr  (sticky_clr),
    .count       (count8),
    .tc          (tc8),
    .active      (act8),
    .wrap_sticky (stk8)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(input int rst_n, input int en, input int ud, input int ld,
                              input int lv, input int clr, input int sclr,
                              input int cnt, input int tcv, input int act, input int stk);
    vec_t v;
    v.rst_n = 1'(rst_n); v.en = 1'(en); v.ud = 1'(ud); v.ld = 1'(ld);
    v.lv = 3'(lv); v.clr = 1'(clr); v.sclr = 1'(sclr);
    v.cnt = 3'(cnt); v.tc = 1'(tcv); v.act = 1'(act); v.stk = 1'(stk);
    return v;
  endfunction

  // Drives one cycle of inputs, queues the expectation, compares after the edge.
  task automatic apply(input string tag, input vec_t v, input bit chk8, input logic [5:0] e8);
    logic [5:0] exp, got;
    reset      = v.rst_n;
    enable     = v.en;
    up_down    = v.ud;
    load       = v.ld;
    load_value = v.lv;
    clear      = v.clr;
    sticky_clr = v.sclr;
    exp_q.push_back({v.cnt, v.tc, v.act, v.stk});
    if (chk8) exp8_q.push_back(e8);
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    got = {count7, tc7, act7, stk7};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s mod7: got cnt=%0d tc=%b act=%b stk=%b, expected cnt=%0d tc=%b act=%b stk=%b",
               tag, got[5:3], got[2], got[1], got[0], exp[5:3], exp[2], exp[1], exp[0]);
    end
    if (exp8_q.size() > 0) begin
      exp = exp8_q.pop_front();
      got = {count8, tc8, act8, stk8};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s mod8: got cnt=%0d tc=%b act=%b stk=%b, expected cnt=%0d tc=%b act=%b stk=%b",
                 tag, got[5:3], got[2], got[1], got[0], exp[5:3], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; up_down = 1'b1; load = 1'b0;
    load_value = 3'd0; clear = 1'b0; sticky_clr = 1'b0;

`ifndef MOD_COUNTER_PRESCALE_EN
    //             rst en ud ld lv clr sclr  cnt tc act stk
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0));  // reset
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0));  // reset beats enable
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0,   1, 0, 1, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0,   2, 0, 1, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0,   3, 0, 1, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0,   4, 0, 1, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0,   5, 0, 1, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0,   6, 0, 1, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0,   0, 1, 1, 1));  // up wrap
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0,   1, 0, 1, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0,   0, 0, 1, 1));  // down
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0,   6, 1, 1, 1));  // down wrap
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0,   5, 0, 1, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0,   4, 0, 1, 1));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0,   5, 0, 1, 1));  // toggle to up
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0,   4, 0, 1, 1));  // toggle to down
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,   4, 0, 0, 1));  // hold
    vecs.push_back(mk(1, 1, 1, 1, 7, 0, 0,   6, 0, 0, 1));  // saturating load, enable ignored
    vecs.push_back(mk(1, 0, 1, 1, 3, 0, 0,   3, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 1, 6, 0, 0,   6, 0, 0, 1));
    vecs.push_back(mk(1, 1, 1, 0, 0, 1, 0,   0, 0, 0, 1));  // clear beats wrap step
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 1,   0, 0, 0, 0));  // sticky_clr
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1,   6, 1, 1, 1));  // wrap beats sticky_clr
    vecs.push_back(mk(1, 0, 1, 1, 2, 1, 0,   0, 0, 0, 1));  // clear beats load
    vecs.push_back(mk(1, 0, 1, 1, 2, 0, 0,   2, 0, 0, 1));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0,   3, 0, 1, 1));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0,   4, 0, 1, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0));  // reset mid-count
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0,   1, 0, 1, 0));  // first step from 0

    for (int i = 0; i < vecs.size(); i++) begin
      apply($sformatf("vec%0d", i), vecs[i], 1'b0, 6'd0);
    end

    // MODULUS = 2**WIDTH: load 7 saturates only in the mod-7 instance.
    apply("m8_reset", mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, {3'd0, 3'b000});
    apply("m8_load7", mk(1, 0, 1, 1, 7, 0, 0, 6, 0, 0, 0), 1'b1, {3'd7, 3'b000});
    apply("m8_upwrap", mk(1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1), 1'b1, {3'd0, 3'b111});
    apply("m8_dnwrap", mk(1, 1, 0, 0, 0, 0, 0, 6, 1, 1, 1), 1'b1, {3'd7, 3'b111});
    apply("m8_down", mk(1, 1, 0, 0, 0, 0, 0, 5, 0, 1, 1), 1'b1, {3'd6, 3'b011});
`else
    // Prescaler of 4: a step lands on every 4th enabled cycle.
    apply("ps_reset", mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 6'd0);
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 3; j++)
        apply($sformatf("ps_wait%0d_%0d", k, j), mk(1, 1, 1, 0, 0, 0, 0, k, 0, 0, 0), 1'b0, 6'd0);
      apply($sformatf("ps_step%0d", k), mk(1, 1, 1, 0, 0, 0, 0, k + 1, 0, 1, 0), 1'b0, 6'd0);
    end
    apply("ps_hold", mk(1, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0), 1'b0, 6'd0);
    apply("ps_mid1", mk(1, 1, 1, 0, 0, 0, 0, 2, 0, 0, 0), 1'b0, 6'd0);
    apply("ps_mid2", mk(1, 1, 1, 0, 0, 0, 0, 2, 0, 0, 0), 1'b0, 6'd0);
    apply("ps_load", mk(1, 1, 1, 1, 5, 0, 0, 5, 0, 0, 0), 1'b0, 6'd0);
    for (int j = 0; j < 3; j++)
      apply($sformatf("ps_phase%0d", j), mk(1, 1, 1, 0, 0, 0, 0, 5, 0, 0, 0), 1'b0, 6'd0);
    apply("ps_step_after_load", mk(1, 1, 1, 0, 0, 0, 0, 6, 0, 1, 0), 1'b0, 6'd0);
    for (int j = 0; j < 3; j++)
      apply($sformatf("ps_wrapwait%0d", j), mk(1, 1, 1, 0, 0, 0, 0, 6, 0, 0, 0), 1'b0, 6'd0);
    apply("ps_wrap", mk(1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1), 1'b0, 6'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
